// File: rtl/rva_core_preg_free_list.sv
// Physical-register free list for rename: in-order allocation, retirement reclaim,
// and one-cycle flush rewind to the committed head.
module rva_core_preg_free_list #(
    parameter int unsigned PHY_REG_CNT  = 64,
    parameter int unsigned ARCH_REG_CNT = 32,
    parameter int unsigned ALLOC_WIDTH  = 4,
    parameter int unsigned FREE_WIDTH   = 4,
    parameter int unsigned PADDR_WIDTH  = $clog2(PHY_REG_CNT),
    localparam int unsigned CAP         = PHY_REG_CNT - ARCH_REG_CNT,
    localparam int unsigned CNT_W       = $clog2(CAP + 1),
    localparam int unsigned PTR_W       = $clog2(CAP),
    localparam int unsigned CMT_W       = $clog2(ALLOC_WIDTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ALLOC_WIDTH-1:0]             alloc_req_i,
    output logic                               alloc_gnt_o,
    output logic [ALLOC_WIDTH*PADDR_WIDTH-1:0] alloc_paddr_o,
    input  logic [CMT_W-1:0]                   commit_cnt_i,
    input  logic                               flush_i,
    input  logic [FREE_WIDTH-1:0]              free_vld_i,
    input  logic [FREE_WIDTH*PADDR_WIDTH-1:0]  free_paddr_i,
    output logic [CNT_W-1:0]                   free_cnt_o,
    output logic                               err_o
);

    typedef logic [PADDR_WIDTH-1:0] rva_core_paddr_t;

    localparam logic [CNT_W:0]   CAP_P = (CNT_W + 1)'(CAP);
    localparam logic [CNT_W+1:0] CAP_W = (CNT_W + 2)'(CAP);

    rva_core_paddr_t  entry_q [CAP];
    logic [PTR_W-1:0] head_q, commit_head_q, tail_q;
    logic [CNT_W-1:0] free_cnt_q, spec_cnt_q;
    logic             err_q;

    logic [CNT_W-1:0] req_n, granted_n, freed_n, commit_n;
    logic [CNT_W-1:0] lane_off [ALLOC_WIDTH];
    logic [CNT_W-1:0] free_off [FREE_WIDTH];
    logic [CNT_W+1:0] free_cnt_ext;
    logic [CNT_W:0]   spec_avail;
    logic             over_commit;

    // Mod-CAP add; inc is always below CAP so one conditional subtract suffices.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] s;
        s = (CNT_W + 1)'(p) + (CNT_W + 1)'(inc);
        if (s >= CAP_P) s = s - CAP_P;
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        req_n = '0;
        for (int k = 0; k < int'(ALLOC_WIDTH); k++) begin
            lane_off[k] = req_n;
            req_n       = req_n + CNT_W'(alloc_req_i[k]);
        end
        freed_n = '0;
        for (int j = 0; j < int'(FREE_WIDTH); j++) begin
            free_off[j] = freed_n;
            freed_n     = freed_n + CNT_W'(free_vld_i[j]);
        end
        commit_n = CNT_W'(commit_cnt_i);

        alloc_gnt_o = !rst && !flush_i && (req_n <= free_cnt_q);
        granted_n   = alloc_gnt_o ? req_n : '0;

        for (int k = 0; k < int'(ALLOC_WIDTH); k++) begin
            alloc_paddr_o[k*PADDR_WIDTH +: PADDR_WIDTH] =
                rst ? '0 : entry_q[ptr_add(head_q, lane_off[k])];
        end

        // Wide enough that over-release and underflow both land above CAP.
        free_cnt_ext = (CNT_W + 2)'(free_cnt_q) + (CNT_W + 2)'(freed_n) - (CNT_W + 2)'(granted_n);
        if (flush_i) begin
            free_cnt_ext = free_cnt_ext + (CNT_W + 2)'(spec_cnt_q) - (CNT_W + 2)'(commit_n);
        end
        spec_avail  = (CNT_W + 1)'(spec_cnt_q) + (CNT_W + 1)'(granted_n);
        over_commit = (CNT_W + 1)'(commit_n) > spec_avail;
    end

    assign free_cnt_o = free_cnt_q;
    assign err_o      = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CAP); i++) begin
                entry_q[i] <= PADDR_WIDTH'(ARCH_REG_CNT + i);
            end
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= '0;
            free_cnt_q    <= CNT_W'(CAP);
            spec_cnt_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            for (int j = 0; j < int'(FREE_WIDTH); j++) begin
                if (free_vld_i[j]) begin
                    entry_q[ptr_add(tail_q, free_off[j])] <=
                        free_paddr_i[j*PADDR_WIDTH +: PADDR_WIDTH];
                end
            end
            tail_q        <= ptr_add(tail_q, freed_n);
            commit_head_q <= ptr_add(commit_head_q, commit_n);
            head_q        <= flush_i ? ptr_add(commit_head_q, commit_n)
                                     : ptr_add(head_q, granted_n);
            spec_cnt_q    <= flush_i ? '0 : spec_cnt_q + granted_n - commit_n;
            free_cnt_q    <= free_cnt_ext[CNT_W-1:0];
            err_q         <= err_q || (free_cnt_ext > CAP_W) || over_commit;
        end
    end

endmodule

// File: tb/tb_rva_core_preg_free_list.sv
// Scoreboard bench for the preg free list: directed cycles push expected outputs,
// a negedge monitor pops and compares.
module tb_rva_core_preg_free_list;

    logic        clk;
    logic        rst;
    logic [3:0]  alloc_req;
    logic        alloc_gnt;
    logic [23:0] alloc_paddr;
    logic [2:0]  commit_cnt;
    logic        flush;
    logic [3:0]  free_vld;
    logic [23:0] free_paddr;
    logic [5:0]  free_cnt;
    logic        err;

    rva_core_preg_free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req_i  (alloc_req),
        .alloc_gnt_o  (alloc_gnt),
        .alloc_paddr_o(alloc_paddr),
        .commit_cnt_i (commit_cnt),
        .flush_i      (flush),
        .free_vld_i   (free_vld),
        .free_paddr_i (free_paddr),
        .free_cnt_o   (free_cnt),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        cg;
        logic        g;
        logic [3:0]  pm;
        logic [23:0] pa;
        logic        cf;
        logic [5:0]  fc;
        logic        e;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [23:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected during it.
    task automatic step(input logic r, input logic [3:0] req, input logic [2:0] cmt,
                        input logic fl, input logic [3:0] vld, input logic [23:0] fpa,
                        input string nm, input logic cg, input logic g, input logic [3:0] pm,
                        input logic [23:0] pa, input logic cf, input logic [5:0] fc,
                        input logic e);
        exp_t x;
        rst        = r;
        alloc_req  = req;
        commit_cnt = cmt;
        flush      = fl;
        free_vld   = vld;
        free_paddr = fpa;
        x = '{cg: cg, g: g, pm: pm, pa: pa, cf: cf, fc: fc, e: e};
        exp_q.push_back(x);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        x;
            string       nm;
            logic [23:0] m;
            logic        bad;
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            for (int k = 0; k < 4; k++) m[k*6 +: 6] = {6{x.pm[k]}};
            bad = 1'b0;
            if (x.cg && alloc_gnt !== x.g) bad = 1'b1;
            if ((alloc_paddr & m) !== (x.pa & m)) bad = 1'b1;
            if (x.cf && free_cnt !== x.fc) bad = 1'b1;
            if (err !== x.e) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s: got gnt=%b paddr=%h free_cnt=%0d err=%b, want gnt=%b paddr=%h (mask %b) free_cnt=%0d err=%b",
                         nm, alloc_gnt, alloc_paddr & m, free_cnt, err, x.g, x.pa & m, x.pm,
                         x.fc, x.e);
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; alloc_req = '0; commit_cnt = '0; flush = 1'b0;
        free_vld = '0; free_paddr = '0;
        @(posedge clk);
        #1;

        // Reset holds outputs quiet
        step(1, 4'hf, 0, 0, 0, 0, "reset_quiet", 1, 0, 4'hf, 24'h0, 1, 32, 0);

        // T1/T2: eight full grants, each committed immediately
        for (int i = 0; i < 8; i++) begin
            step(0, 4'hf, 4, 0, 0, 0, "full_grant", 1, 1, 4'hf,
                 pk(32 + 4*i, 33 + 4*i, 34 + 4*i, 35 + 4*i), 1, 6'(32 - 4*i), 0);
        end
        step(0, 4'b0001, 0, 0, 4'b0001, pk(40, 0, 0, 0), "exhausted_deny",
             1, 0, 4'h0, 24'h0, 1, 0, 0);
        step(0, 4'b0001, 1, 0, 0, 0, "reuse_freed", 1, 1, 4'b0001, pk(40, 0, 0, 0), 1, 1, 0);

        // T3: sparse lanes, non-requesting lanes show their would-be entry
        step(1, 4'hf, 0, 0, 0, 0, "reset_mid", 1, 0, 4'hf, 24'h0, 1, 0, 0);
        step(0, 4'b1010, 2, 0, 0, 0, "sparse", 1, 1, 4'hf, pk(32, 32, 33, 33), 1, 32, 0);
        step(0, 4'b0001, 1, 0, 0, 0, "sparse_head", 1, 1, 4'b0001, pk(34, 0, 0, 0), 1, 30, 0);

        // T4: flush rewinds to committed head plus same-cycle commit
        step(1, 4'h0, 0, 0, 0, 0, "reset_t4", 1, 0, 4'h0, 24'h0, 1, 29, 0);
        step(0, 4'hf, 0, 0, 0, 0, "t4_alloc4", 1, 1, 4'hf, pk(32, 33, 34, 35), 1, 32, 0);
        step(0, 4'b0011, 2, 0, 0, 0, "t4_alloc2", 1, 1, 4'hf, pk(36, 37, 38, 38), 1, 28, 0);
        step(0, 4'b0001, 1, 1, 0, 0, "t4_flush", 1, 0, 4'h0, 24'h0, 1, 26, 0);
        step(0, 4'b0001, 1, 0, 0, 0, "t4_after", 1, 1, 4'b0001, pk(35, 0, 0, 0), 1, 29, 0);

        // T6: alloc 2, free 3, commit 1 in one cycle
        step(0, 4'b0011, 1, 0, 4'b0111, pk(1, 2, 3, 0), "t6_mixed",
             1, 1, 4'hf, pk(36, 37, 38, 38), 1, 28, 0);
        for (int m = 0; m < 6; m++) begin
            step(0, 4'hf, 4, 0, 0, 0, "t6_drain", 1, 1, 4'hf,
                 pk(38 + 4*m, 39 + 4*m, 40 + 4*m, 41 + 4*m), 1, 6'(29 - 4*m), 0);
        end
        step(0, 4'hf, 4, 0, 0, 0, "t6_wrap", 1, 1, 4'hf, pk(62, 63, 1, 2), 1, 5, 0);
        step(0, 4'b0001, 1, 0, 0, 0, "t6_third", 1, 1, 4'b0001, pk(3, 0, 0, 0), 1, 1, 0);

        // T5: 40 alloc/free pairs across the wrap, then over-release
        step(1, 4'h0, 0, 0, 0, 0, "reset_t5", 1, 0, 4'h0, 24'h0, 1, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 4'b0001, 1, 0, 4'b0001, pk(i % 32, 0, 0, 0), "wrap_pair", 1, 1, 4'b0001,
                 pk((i < 32) ? 32 + i : i - 32, 0, 0, 0), 1, 32, 0);
        end
        step(0, 4'h0, 0, 0, 4'b0001, pk(5, 0, 0, 0), "over_release", 1, 1, 4'h0, 24'h0, 1, 32, 0);
        step(0, 4'h0, 0, 0, 0, 0, "err_set", 1, 1, 4'h0, 24'h0, 0, 0, 1);
        step(0, 4'h0, 0, 0, 0, 0, "err_sticky", 1, 1, 4'h0, 24'h0, 0, 0, 1);
        step(1, 4'h0, 0, 0, 0, 0, "err_until_rst", 1, 0, 4'h0, 24'h0, 0, 0, 1);
        step(0, 4'h0, 1, 0, 0, 0, "over_commit", 1, 1, 4'h0, 24'h0, 1, 32, 0);
        step(0, 4'h0, 0, 0, 0, 0, "over_commit_err", 1, 1, 4'h0, 24'h0, 1, 32, 1);
        step(1, 4'h0, 0, 0, 0, 0, "final_reset", 1, 0, 4'h0, 24'h0, 1, 32, 1);

        rst = 1'b0; alloc_req = '0; commit_cnt = '0; free_vld = '0;
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
